// File: rtl/c2_to_sm_serial.sv
// ---------------------------------------------------------------------------
// c2_to_sm_serial
//
// Purpose:
//   Bit-serial two's-complement to sign-magnitude decoder. One WIDTH-bit
//   word is accepted on a valid/ready handshake. The magnitude is rebuilt
//   LSB-first, one bit per clock, using the "copy bits up to and including
//   the first 1, invert every bit after it" rule for negative words. The
//   result (sign, magnitude, most-negative flag) is then offered on an
//   output valid/ready handshake and held until the consumer takes it.
//
// Optional feature (macro C2SM_FAST_POS_EN):
//   When defined, a non-negative word bypasses the serial walk. Its value
//   is already its own magnitude, so it is written straight to the outputs
//   at the capture edge and the block goes directly to DONE. Negative words
//   always take the serial path.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_valid    in   in_data is valid
//   in_ready    out  block can accept a word (IDLE only)
//   in_data     in   WIDTH-bit two's-complement operand
//   out_valid   out  result valid (DONE only)
//   out_ready   in   consumer accepts result
//   out_sign    out  1 = negative
//   out_mag     out  WIDTH-bit unsigned magnitude
//   out_minneg  out  input was the most-negative value (100...0)
// ---------------------------------------------------------------------------
module c2_to_sm_serial #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_minneg
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // Working registers for the serial walk
  logic [WIDTH-1:0]  r_sh;        // operand, consumed from bit 0
  logic [WIDTH-1:0]  r_acc;       // magnitude being assembled
  logic [CNT_W-1:0]  r_cnt;       // bit position being processed
  logic              r_seen_one;  // a 1 has already been passed (negative words)
  logic              r_sign;      // sign of the captured word
  logic              r_minneg;    // captured word was 100...0

  // Result registers; they only change when a new result is complete
  logic [WIDTH-1:0]  r_out_mag;
  logic              r_out_sign;
  logic              r_out_minneg;

  logic              w_bit_in;
  logic              w_mag_bit;
  logic              w_last;
  logic              w_fast_pos;
  logic              w_in_minneg;
  logic [WIDTH-1:0]  w_acc_upd;

  assign w_bit_in  = r_sh[0];
  // After the first 1 of a negative word every remaining bit is inverted;
  // up to and including that 1 the bits are copied unchanged.
  assign w_mag_bit = (r_sign & r_seen_one) ? ~w_bit_in : w_bit_in;
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_CNT);

  assign w_in_minneg = in_data[WIDTH-1] & (in_data[WIDTH-2:0] == '0);

`ifdef C2SM_FAST_POS_EN
  assign w_fast_pos = ~in_data[WIDTH-1];
`else
  assign w_fast_pos = 1'b0;
`endif

  // Accumulator update: only the bit at position r_cnt takes the new
  // magnitude bit, every other bit keeps its value.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_acc_bit
      assign w_acc_upd[gi] = (r_cnt == CNT_W'(gi)) ? w_mag_bit : r_acc[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_fast_pos ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh         <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_seen_one   <= 1'b0;
      r_sign       <= 1'b0;
      r_minneg     <= 1'b0;
      r_out_mag    <= '0;
      r_out_sign   <= 1'b0;
      r_out_minneg <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh       <= in_data;
            r_sign     <= in_data[WIDTH-1];
            r_minneg   <= w_in_minneg;
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_acc      <= '0;
            if (w_fast_pos) begin
              // Non-negative word: its bits already are the magnitude.
              r_out_mag    <= in_data;
              r_out_sign   <= 1'b0;
              r_out_minneg <= 1'b0;
            end
          end
        end
        SHIFT: begin
          r_acc <= w_acc_upd;
          r_sh  <= r_sh >> 1;
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (r_sign) begin
            r_seen_one <= r_seen_one | w_bit_in;
          end
          if (w_last) begin
            // Publish the finished word; include the bit processed this edge.
            r_out_mag    <= w_acc_upd;
            r_out_sign   <= r_sign;
            r_out_minneg <= r_minneg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_mag    = r_out_mag;
  assign out_sign   = r_out_sign;
  assign out_minneg = r_out_minneg;

endmodule

// File: tb/tb_c2_to_sm_serial.sv
// ---------------------------------------------------------------------------
// tb_c2_to_sm_serial
//
// Self-checking bench for c2_to_sm_serial (WIDTH=6). Expected results come
// from an arithmetic reference: the word is read as a signed integer and its
// absolute value and sign are taken directly. Latency expectations follow
// the C2SM_FAST_POS_EN macro if the bench is built with it.
// ---------------------------------------------------------------------------
module tb_c2_to_sm_serial;

  localparam int WIDTH   = 6;
  localparam int LAT_NEG = WIDTH + 1;
`ifdef C2SM_FAST_POS_EN
  localparam int LAT_POS = 1;
`else
  localparam int LAT_POS = WIDTH + 1;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             out_minneg;

  int errors = 0;
  int checks = 0;

  c2_to_sm_serial #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_mag    (out_mag),
    .out_minneg (out_minneg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before t=200000");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ref_value(input logic [WIDTH-1:0] d);
    int u;
    u = int'(d);
    return (u >= (1 << (WIDTH - 1))) ? u - (1 << WIDTH) : u;
  endfunction

  function automatic logic [WIDTH-1:0] ref_mag(input logic [WIDTH-1:0] d);
    int v;
    v = ref_value(d);
    return WIDTH'((v < 0) ? -v : v);
  endfunction

  function automatic logic ref_sign(input logic [WIDTH-1:0] d);
    return ref_value(d) < 0;
  endfunction

  function automatic logic ref_minneg(input logic [WIDTH-1:0] d);
    return ref_value(d) == -(1 << (WIDTH - 1));
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] d);
    return (ref_value(d) < 0) ? LAT_NEG : LAT_POS;
  endfunction

  // ---------------- driver (no checking) ----------------
  // Waits (bounded) for in_ready, presents one word for one edge, then counts
  // edges from the capture edge until out_valid is seen. Leaves the bench
  // sampling #1 after the edge where out_valid was first observed.
  task automatic do_word(input logic [WIDTH-1:0] d, output int lat,
                         output logic s, output logic [WIDTH-1:0] m,
                         output logic mn);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s  = out_sign;
    m  = out_mag;
    mn = out_minneg;
    $display("word in=%b ref=%0d -> sign=%0b mag=%0d minneg=%0b lat=%0d",
             d, ref_value(d), s, m, mn, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mag !== '0 ||
        out_sign !== 1'b0 || out_minneg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b mag=%b sign=%b minneg=%b, required 0 1 000000 0 0",
               out_valid, in_ready, out_mag, out_sign, out_minneg);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] vec [6];
    int lat; logic s; logic [WIDTH-1:0] m; logic mn;
    vec = '{6'b000101, 6'b111011, 6'b111111, 6'b100000, 6'b000000, 6'b011111};
    out_ready = 1'b1;
    foreach (vec[i]) begin
      do_word(vec[i], lat, s, m, mn);
      checks++;
      if (lat !== ref_lat(vec[i])) begin
        errors++;
        $display("FAIL directed_latency in=%b: got %0d edges, required %0d", vec[i], lat, ref_lat(vec[i]));
      end
      checks++;
      if (s !== ref_sign(vec[i]) || m !== ref_mag(vec[i]) || mn !== ref_minneg(vec[i])) begin
        errors++;
        $display("FAIL directed_result in=%b: got sign=%b mag=%b minneg=%b, required sign=%b mag=%b minneg=%b",
                 vec[i], s, m, mn, ref_sign(vec[i]), ref_mag(vec[i]), ref_minneg(vec[i]));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic s; logic [WIDTH-1:0] m; logic mn;
    logic [WIDTH-1:0] d;
    d = 6'b111101;
    out_ready = 1'b0;
    do_word(d, lat, s, m, mn);
    checks++;
    if (s !== ref_sign(d) || m !== ref_mag(d) || mn !== ref_minneg(d) || lat !== ref_lat(d)) begin
      errors++;
      $display("FAIL bp_result: got sign=%b mag=%b minneg=%b lat=%0d, required sign=%b mag=%b minneg=%b lat=%0d",
               s, m, mn, lat, ref_sign(d), ref_mag(d), ref_minneg(d), ref_lat(d));
    end
    // A second word is offered but must not be taken while DONE is held.
    in_data  = 6'b000111;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== ref_sign(d) ||
          out_mag !== ref_mag(d) || out_minneg !== ref_minneg(d)) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b sign=%b mag=%b minneg=%b, required 1 0 %b %b %b",
                 c, out_valid, in_ready, out_sign, out_mag, out_minneg,
                 ref_sign(d), ref_mag(d), ref_minneg(d));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_not_consumed: got ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic s; logic [WIDTH-1:0] m; logic mn;
    logic [WIDTH-1:0] d;
    out_ready = 1'b1;
    in_data   = 6'b110010;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_mag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state: got valid=%b mag=%b ready=%b, required 0 000000 1",
               out_valid, out_mag, in_ready);
    end
    d = 6'b101101;
    do_word(d, lat, s, m, mn);
    checks++;
    if (s !== ref_sign(d) || m !== ref_mag(d) || mn !== ref_minneg(d) || lat !== ref_lat(d)) begin
      errors++;
      $display("FAIL reset_mid_after: got sign=%b mag=%b minneg=%b lat=%0d, required sign=%b mag=%b minneg=%b lat=%0d",
               s, m, mn, lat, ref_sign(d), ref_mag(d), ref_minneg(d), ref_lat(d));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat; logic s; logic [WIDTH-1:0] m; logic mn;
    logic [WIDTH-1:0] d;
    out_ready = 1'b1;
    for (int k = 0; k < (1 << WIDTH); k++) begin
      d = WIDTH'(k);
      do_word(d, lat, s, m, mn);
      checks++;
      if (s !== ref_sign(d) || m !== ref_mag(d) || mn !== ref_minneg(d) || lat !== ref_lat(d)) begin
        errors++;
        $display("FAIL sweep in=%b: got sign=%b mag=%b minneg=%b lat=%0d, required sign=%b mag=%b minneg=%b lat=%0d",
                 d, s, m, mn, lat, ref_sign(d), ref_mag(d), ref_minneg(d), ref_lat(d));
      end
      // Result must be presented exactly once.
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_single in=%b: got valid=%b after accept, required 0", d, out_valid);
      end
    end
  endtask

  task automatic test_random();
    int lat; int h; logic s; logic [WIDTH-1:0] m; logic mn;
    logic [WIDTH-1:0] d;
    for (int k = 0; k < 30; k++) begin
      d = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      h = $urandom_range(0, 3);
      out_ready = 1'b0;
      do_word(d, lat, s, m, mn);
      checks++;
      if (s !== ref_sign(d) || m !== ref_mag(d) || mn !== ref_minneg(d) || lat !== ref_lat(d)) begin
        errors++;
        $display("FAIL random in=%b: got sign=%b mag=%b minneg=%b lat=%0d, required sign=%b mag=%b minneg=%b lat=%0d",
                 d, s, m, mn, lat, ref_sign(d), ref_mag(d), ref_minneg(d), ref_lat(d));
      end
      for (int c = 0; c < h; c++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_mag !== ref_mag(d) || out_sign !== ref_sign(d)) begin
          errors++;
          $display("FAIL random_hold in=%b: got valid=%b sign=%b mag=%b, required 1 %b %b",
                   d, out_valid, out_sign, out_mag, ref_sign(d), ref_mag(d));
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_release in=%b: got valid=%b ready=%b, required 0 1", d, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c2_to_sm_serial.md
Name: c2_to_sm_serial

Overview:
- Bit-serial decoder from two's-complement to sign-magnitude; the inverse of the team's complement/negation datapath.
- Accepts one WIDTH-bit two's-complement word over a valid/ready handshake.
- Recovers the magnitude LSB-first, one bit per clock, using the copy-until-first-1-then-invert rule.
- Presents sign and magnitude on an output valid/ready handshake; sits between the arithmetic units and display/print logic.

Parameters:
WIDTH, 6, word width of input and magnitude (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  two's-complement operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sign  output  1  1 = negative
out_mag  output  WIDTH  unsigned magnitude
out_minneg  output  1  input was most-negative value (100...0)

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high. Nothing is asynchronous.
- Reset (reset=1 at a rising edge):
  - state=IDLE; out_valid=0, out_sign=0, out_mag=0, out_minneg=0.
  - Bit counter and seen_one flag cleared; in_ready=1 after that edge.
- Reset mid-operation (SHIFT or DONE) aborts; the partial word is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture in_data into shift register sh, sign=in_data[WIDTH-1], cnt=0, seen_one=0, clear out_mag accumulator, go to SHIFT.
- SHIFT:
  - in_ready=0. Each edge processes b=sh[0]:
    - sign=0: magnitude bit = b.
    - sign=1: magnitude bit = seen_one ? ~b : b; then seen_one |= b.
  - Magnitude bit is written to position cnt; sh shifts right; cnt++.
  - After the edge processing cnt=WIDTH-1, go to DONE.
  - Exactly WIDTH cycles in SHIFT.
- DONE:
  - out_valid=1; out_sign, out_mag, out_minneg stable; in_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - Outputs hold indefinitely while out_ready=0.
- Latency: capture edge to out_valid high = WIDTH+1 edges (7 for WIDTH=6).
- Throughput: one word per WIDTH+2 cycles minimum. No overlap: the next word is accepted only in IDLE.
- Arithmetic/width rules:
  - out_mag is unsigned WIDTH bits; no overflow is possible.
  - Most-negative input yields out_mag = 100...0 (2^(WIDTH-1)), out_sign=1, out_minneg=1.
  - out_minneg = sign & (in_data[WIDTH-2:0]==0), registered at capture.
  - Zero input gives out_sign=0, out_mag=0 (no negative zero).
- out_sign, out_mag and out_minneg are undefined-free. They keep the last result after leaving DONE until the next result is written.
- in_valid while busy is ignored (not consumed). The producer holds it until in_ready.

Optional Feature:
- Macro: C2SM_FAST_POS_EN.
- Defined:
  - A word with in_data[WIDTH-1]=0 skips SHIFT.
  - At the capture edge, out_mag=in_data, out_sign=0, out_minneg=0, state goes to DONE.
  - out_valid is high 1 edge after capture.
  - Negative words are unchanged (WIDTH+1 latency).
- Undefined: all words take the SHIFT path; latency is WIDTH+1 edges regardless of sign.

Test Plan:
- Reset then in_data=6'b000101 in_valid=1 one cycle, out_ready=1 -> out_valid after 7 edges (1 edge with C2SM_FAST_POS_EN), out_sign=0, out_mag=6'b000101, out_minneg=0.
- in_data=6'b111011 (-5) -> out_sign=1, out_mag=6'b000101, out_minneg=0. Also in_data=6'b111111 -> out_mag=6'b000001, sign=1.
- in_data=6'b100000 -> out_sign=1, out_mag=6'b100000, out_minneg=1. in_data=6'b000000 -> sign=0, mag=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, outputs constant, in_ready=0, and a second in_valid is not consumed. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset asserted on the 3rd SHIFT cycle -> next edge state IDLE, out_valid=0, out_mag=0, in_ready=1. A new word afterwards decodes correctly.
- Exhaustive sweep of in_data 0..63 back-to-back with out_ready=1 -> each result equals the reference |value| and sign; no word lost or duplicated.
